// File: rtl/gemm_c_writeback.sv
// gemm_c_writeback: ping-pong C tile buffer serialised into word writes with done tracking.
// Define GEMM_WB_RELU_EN to clamp negative elements to zero on the write data path.
module gemm_c_writeback #(
  parameter int OutDataWidth = 32,
  parameter int AddrWidth    = 16,
  parameter int M            = 4,
  parameter int N            = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         tile_valid_i,
  output logic                         tile_ready_o,
  input  logic [AddrWidth-1:0]         tile_addr_i,
  input  logic [OutDataWidth*M*N-1:0]  tile_data_i,
  input  logic                         gemm_done_i,
  output logic                         mem_valid_o,
  input  logic                         mem_ready_i,
  output logic [AddrWidth-1:0]         mem_addr_o,
  output logic [OutDataWidth-1:0]      mem_wdata_o,
  output logic                         busy_o,
  output logic                         overflow_o,
  output logic                         done_o
);
  localparam int E  = M * N;
  localparam int IW = (E > 1) ? $clog2(E) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [1:0] count, count_n;
  logic wp, rp, rp_n, pending, done_q;
  logic [IW-1:0] idx, idx_n;
  logic [AddrWidth-1:0] slot_addr [2];
  logic [OutDataWidth*E-1:0] slot_data [2];
  logic accept, fire, last, bypass;
  logic [AddrWidth-1:0] addr_sel, addr_n;
  logic [OutDataWidth*E-1:0] data_sel;
  logic [OutDataWidth-1:0] elem, wdata_n;

  assign tile_ready_o = count != 2'd2;
  assign accept       = tile_valid_i && tile_ready_o;
  assign fire         = state == SEND && mem_ready_i;
  assign last         = fire && idx == IW'(E - 1);
  assign busy_o       = count != 2'd0;
  assign done_o       = pending && count == 2'd0 && !accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      count       <= '0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      idx         <= '0;
      done_q      <= 1'b0;
      pending     <= 1'b0;
      overflow_o  <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      wp          <= wp ^ accept;
      rp          <= rp_n;
      idx         <= idx_n;
      done_q      <= gemm_done_i;
      pending     <= (gemm_done_i && !done_q) || (pending && !done_o);
      overflow_o  <= overflow_o || (tile_valid_i && !tile_ready_o);
      mem_valid_o <= state_n == SEND;
      if (state_n == SEND) begin
        mem_addr_o  <= addr_n;
        mem_wdata_o <= wdata_n;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      slot_addr[wp] <= tile_addr_i;
      slot_data[wp] <= tile_data_i;
    end
  end

  always_comb begin
    idx_n   = last ? '0 : idx + IW'(fire);
    rp_n    = rp ^ last;
    count_n = count + 2'(accept) - 2'(last);
    state_n = state == IDLE ? (count != 2'd0 ? SEND : IDLE)
                            : (last && count_n == 2'd0 ? IDLE : SEND);
  end

  // A tile landing in the slot that becomes current this edge is forwarded straight from the input
  always_comb begin
    bypass   = accept && wp == rp_n;
    addr_sel = bypass ? tile_addr_i : slot_addr[rp_n];
    data_sel = bypass ? tile_data_i : slot_data[rp_n];
    elem     = data_sel[idx_n*OutDataWidth +: OutDataWidth];
`ifdef GEMM_WB_RELU_EN
    wdata_n  = elem[OutDataWidth-1] ? '0 : elem;
`else
    wdata_n  = elem;
`endif
    addr_n   = AddrWidth'(addr_sel * E + idx_n);
  end
endmodule

// File: tb/tb_gemm_c_writeback.sv
// tb_gemm_c_writeback: directed stimulus with a queue scoreboard checked by a write monitor.
module tb_gemm_c_writeback;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int E  = 16;
  logic clk = 1'b0, rst_n = 1'b0, tile_valid = 1'b0, gemm_done = 1'b0, mem_ready = 1'b0;
  logic tile_ready, mem_valid, busy, overflow, done;
  logic [AW-1:0] tile_addr = '0, mem_addr;
  logic [DW*E-1:0] tile_data = '0;
  logic [DW-1:0] mem_wdata;
  logic [AW+DW-1:0] q[$];
  logic [AW+DW-1:0] held = '0;
  logic stall_prev = 1'b0;
  logic early;
  int checks = 0, errors = 0, nwrites = 0, w0;

  always #5 clk = ~clk;

  gemm_c_writeback dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tile_valid_i(tile_valid), .tile_ready_o(tile_ready),
    .tile_addr_i(tile_addr), .tile_data_i(tile_data),
    .gemm_done_i(gemm_done),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .busy_o(busy), .overflow_o(overflow), .done_o(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef GEMM_WB_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [DW*E-1:0] ramp(input int base);
    logic [DW*E-1:0] d;
    for (int i = 0; i < E; i++) d[i*DW +: DW] = DW'(base + i);
    return d;
  endfunction

  task automatic send(input logic [AW-1:0] a, input logic [DW*E-1:0] d, input bit keep, input bit dn);
    tile_valid = 1'b1;
    tile_addr  = a;
    tile_data  = d;
    gemm_done  = dn;
    if (keep)
      for (int i = 0; i < E; i++) q.push_back({AW'(int'(a) * E + i), relu(d[i*DW +: DW])});
    @(posedge clk); #1;
    tile_valid = 1'b0;
    gemm_done  = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int bound);
    for (int i = 0; i < bound && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && stall_prev)
      check("stall_hold", 64'({mem_valid, mem_addr, mem_wdata}), 64'({1'b1, held}));
    stall_prev = rst_n && mem_valid && !mem_ready;
    held = {mem_addr, mem_wdata};
    if (rst_n && mem_valid && mem_ready) begin
      nwrites++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_wdata);
      end else
        check("write", 64'({mem_addr, mem_wdata}), 64'(q.pop_front()));
    end
  end

  initial begin
    logic [DW*E-1:0] rd;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({tile_ready, mem_valid, busy, overflow, done}), 64'(5'b10000));
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    // single tile: first word presented one edge after acceptance, then 16 back-to-back
    send(16'd3, ramp(100), 1'b1, 1'b0);
    check("valid_at_accept", 64'(mem_valid), 64'd0);
    check("busy_after_accept", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("first_word", 64'({mem_valid, mem_addr, mem_wdata}), 64'({1'b1, 16'd48, 32'd100}));
    repeat (16) @(posedge clk);
    #1;
    check("single_drained", 64'(q.size()), 64'd0);
    check("single_idle", 64'({mem_valid, busy}), 64'd0);
    // back-pressure with mem_ready toggling every cycle
    send(16'd5, ramp(200), 1'b1, 1'b0);
    for (int i = 0; i < 80 && q.size() != 0; i++) begin
      mem_ready = ~mem_ready;
      @(posedge clk); #1;
    end
    check("bp_drained", 64'(q.size()), 64'd0);
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // full buffer and overflow
    send(16'd1, ramp(400), 1'b1, 1'b0);
    check("ready_one_slot", 64'(tile_ready), 64'd1);
    send(16'd2, ramp(500), 1'b1, 1'b0);
    check("ready_full", 64'(tile_ready), 64'd0);
    check("no_overflow_yet", 64'(overflow), 64'd0);
    send(16'd7, ramp(600), 1'b0, 1'b0);
    check("overflow_set", 64'(overflow), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("overflow_sticky", 64'(overflow), 64'd1);
    mem_ready = 1'b1;
    wait_empty("full_drained", 40);
    check("full_idle", 64'({busy, tile_ready}), 64'(2'b01));
    // done ordering with a tile accepted alongside gemm_done
    send(16'd0, ramp(10), 1'b1, 1'b1);
    early = 1'b0;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      if (done) early = 1'b1;
      @(posedge clk); #1;
    end
    check("done_not_early", 64'(early), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("done_single", 64'(done), 64'd0);
    gemm_done = 1'b1;
    @(posedge clk); #1;
    gemm_done = 1'b0;
    check("done_empty", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("done_empty_single", 64'(done), 64'd0);
    // reset mid-drain after the fifth write
    w0 = nwrites;
    send(16'd9, ramp(300), 1'b1, 1'b0);
    for (int i = 0; i < 30 && nwrites - w0 < 5; i++) begin
      @(posedge clk); #1;
    end
    check("writes_before_reset", 64'(nwrites - w0), 64'd5);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", 64'({tile_ready, mem_valid, busy, overflow, done}), 64'(5'b10000));
    check("midrst_addr_data", 64'({mem_addr, mem_wdata}), 64'd0);
    q.delete();
    w0 = nwrites;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_write_after_reset", 64'(nwrites - w0), 64'd0);
    check("idle_after_reset", 64'({mem_valid, busy}), 64'd0);
    // sign handling of negative, zero and positive elements
    rd = ramp(20);
    rd[0 +: DW]    = 32'hFFFF_FFFB;
    rd[DW +: DW]   = 32'd0;
    rd[2*DW +: DW] = 32'd7;
    send(16'd2, rd, 1'b1, 1'b0);
    @(posedge clk); #1;
`ifdef GEMM_WB_RELU_EN
    check("relu_first", 64'({mem_addr, mem_wdata}), 64'({16'd32, 32'd0}));
`else
    check("relu_first", 64'({mem_addr, mem_wdata}), 64'({16'd32, 32'hFFFF_FFFB}));
`endif
    wait_empty("relu_drained", 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gemm_c_writeback.md
# gemm_c_writeback

Output writeback stage that sits directly downstream of the GeMM accelerator top. Each cycle the accelerator asserts its C write enable, it presents one full M×N result tile. This block captures that tile into a two-entry ping-pong tile buffer. It then serialises the tile into single-element writes on a narrow, word-addressed SRAM C port with valid/ready back-pressure. Once the accelerator signals completion and every buffered element has been written, the block reports completion.

## Interface
- `OutDataWidth`, 32: width of one result element.
- `AddrWidth`, 16: width of tile address and word address.
- `M`, 4: tile rows.
- `N`, 4: tile columns; a tile holds E = M*N elements.
- `clk_i`  in  1  clock; everything is sampled on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `tile_valid_i`  in  1  tile present; wired to the accelerator's C write enable.
- `tile_ready_o`  out  1  a free buffer slot exists.
- `tile_addr_i`  in  AddrWidth  tile index; wired to the accelerator's C address.
- `tile_data_i`  in  OutDataWidth*E  tile; element idx = m*N+n occupies bits [idx*OutDataWidth +: OutDataWidth].
- `gemm_done_i`  in  1  one-cycle accelerator done pulse.
- `mem_valid_o`  out  1  word write request.
- `mem_ready_i`  in  1  SRAM accepts the word.
- `mem_addr_o`  out  AddrWidth  word address.
- `mem_wdata_o`  out  OutDataWidth  word data.
- `busy_o`  out  1  at least one slot is occupied.
- `overflow_o`  out  1  sticky; a tile arrived while no slot was free.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- Buffer: 2 slots, each holding {tile_addr, tile_data}. Write pointer wp, read pointer rp and count (0..2) are registered.
- Accept: when tile_valid_i && tile_ready_o, the tile is stored in slot wp, wp toggles and count increments.
- Drop: when tile_valid_i && !tile_ready_o, the tile is discarded and overflow_o is set. overflow_o clears only on reset.
- Serialiser FSM states:
  - IDLE: count==0. Moves to SEND when count>0, with element counter idx=0.
  - SEND: presents element idx of slot rp. On mem_valid_o && mem_ready_i, idx increments. When idx reaches E-1 and the word is accepted, the slot is released, rp toggles, count decrements and idx resets to 0. The FSM then stays in SEND if another slot is occupied (including one accepted in that same cycle); otherwise it returns to IDLE.
- Address: mem_addr_o = tile_addr*E + idx, computed modulo 2^AddrWidth, so wrap-around is silent. Tiles are stored blocked, each tile contiguous in row-major order.
- Simultaneous accept and release in one cycle: count is unchanged and both pointers move.
- Done tracking:
  - A rising gemm_done_i sets a sticky pending flag.
  - done_o pulses for exactly one cycle on the first cycle where pending && count==0 && no accept is occurring; pending then clears.
  - A tile accepted in the same cycle as gemm_done_i is written before done_o.
- Reset mid-operation: all in-flight tiles are discarded. No write completes after reset asserts.

## Timing
- Reset values: tile_ready_o=1, mem_valid_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, overflow_o=0, done_o=0. Internal state: count=0, wp=rp=0, idx=0, pending=0, FSM in IDLE.
- tile_ready_o = (count<2). It is registered-state only, with no combinational path from mem_ready_i.
- mem_valid_o, mem_addr_o and mem_wdata_o are registered outputs.
  - A tile accepted at edge T produces its first word (idx 0) at T+1 when the buffer was empty.
  - mem_valid_o, mem_addr_o and mem_wdata_o are held stable while mem_valid_o && !mem_ready_i.
- Throughput: one word per cycle under mem_ready_i=1. A tile drains in E cycles, and consecutive tiles write back-to-back with no bubble.
- Latency from gemm_done_i to done_o:
  - Empty buffer: done_o pulses at the edge following the cycle in which gemm_done_i is sampled.
  - Otherwise: one cycle after the last word is accepted.

## Configuration
- `GEMM_WB_RELU_EN` defined: each element is treated as signed. Negative values are written as 0; non-negative values pass through unchanged. The clamp is applied on the path to the mem_wdata_o register, and address and timing are identical.
- `GEMM_WB_RELU_EN` undefined: elements pass through bit-exact.

## Test plan
- Single tile with M=N=4: tile_addr=3, element idx holds value idx+100, mem_ready_i=1. Required: 16 writes at addresses 48..63 with data 100..115, one per consecutive cycle starting at T+1.
- Back-pressure: same tile with mem_ready_i toggling 1,0,1,0. Required: signals held stable on stall cycles, 16 writes, correct order, none duplicated or skipped.
- Full buffer and overflow: 3 tiles on consecutive cycles with mem_ready_i=0. Required: the first 2 are accepted and tile_ready_o=0 after the 2nd. The 3rd is dropped and overflow_o=1 stays set. Releasing mem_ready_i then gives 32 writes.
- Done ordering: tile with tile_addr=0 accepted together with gemm_done_i. Required: done_o is a single pulse one cycle after the 16th write. With an empty buffer, gemm_done_i alone gives done_o at the next edge.
- Reset mid-drain: assert rst_ni=0 after the 5th write. Required: all outputs return to their reset values immediately, and no further writes occur after release.
- RELU build: element values -5, 0, 7. Required: written 0, 0, 7 with `GEMM_WB_RELU_EN` defined, and -5 (0xFFFFFFFB), 0, 7 without it.
